// File: rtl/avalon_rw_ctrl_if.sv
// Avalon-MM read/write master bundle between avalon_rw_ctrl and the RAM fabric.
// master: driven by the sequencer (rd_address/rd_read, wr_address/wr_write/wr_writedata).
// slave:  driven by the memory side (waitrequests, rd_readdata/rd_readdatavalid).
interface avalon_rw_ctrl_if #(
  parameter int DW = 32
);
  logic [DW-1:0] rd_address;
  logic          rd_read;
  logic          rd_waitrequest;
  logic [DW-1:0] rd_readdata;
  logic          rd_readdatavalid;
  logic [DW-1:0] wr_address;
  logic          wr_write;
  logic [DW-1:0] wr_writedata;
  logic          wr_waitrequest;

  modport master (
    output rd_address, rd_read,
    input  rd_waitrequest, rd_readdata, rd_readdatavalid,
    output wr_address, wr_write, wr_writedata,
    input  wr_waitrequest
  );

  modport slave (
    input  rd_address, rd_read,
    output rd_waitrequest, rd_readdata, rd_readdatavalid,
    input  wr_address, wr_write, wr_writedata,
    output wr_waitrequest
  );
endinterface

// File: rtl/avalon_rw_ctrl.sv
// Purpose: copy param_iolen words from param_raddr to param_waddr through a 2^FW word FIFO.
// Latency: rd_read the cycle after config_done; task_done the cycle after the last write accept.
// Backpressure: waitrequest holds the request; reads are credit-limited by FIFO space + reads in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   config_done                   one-cycle start pulse (ignored unless idle)
//   param_raddr/waddr/iolen       transfer parameters, latched on config_done
//   task_done                     one-cycle completion pulse
//   busy                          high while a transfer is in progress
//   av (master)                   Avalon read and write masters
module avalon_rw_ctrl #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int FW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  config_done,
  input  logic [DW-1:0]         param_raddr,
  input  logic [DW-1:0]         param_waddr,
  input  logic [AW-1:0]         param_iolen,
  output logic                  task_done,
  output logic                  busy,
  avalon_rw_ctrl_if.master      av
);

  localparam int DEPTH = 1 << FW;
  localparam int CW    = FW + 1;
  localparam logic [DW-1:0] STRIDE  = DW'(DW / 8);
  // 2^FW expressed at credit-sum width (one bit wider than a single counter).
  localparam logic [FW+1:0] CREDITS = {2'b01, {FW{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   rd_issued;
  logic [AW-1:0]   wr_done;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_wptr;
  logic [FW-1:0]   fifo_rptr;
  logic [DW-1:0]   fifo_mem [DEPTH];

  logic            rd_acc;
  logic            rd_ret;
  logic            wr_acc;
  logic            fifo_empty;
  logic [AW-1:0]   issued_nxt;
  logic [CW-1:0]   out_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [FW+1:0]   credit_nxt;
  logic            last_write;

  assign rd_acc     = av.rd_read && !av.rd_waitrequest;
  // Returning beats only count while a transfer runs; stragglers from an
  // aborted transfer land in IDLE and are dropped.
  assign rd_ret     = (state == RUN) && av.rd_readdatavalid;
  assign fifo_empty = (fifo_count == '0);
  assign wr_acc     = av.wr_write && !av.wr_waitrequest;

  // Write side is first-word-fall-through straight off the FIFO head. The
  // request is a pure function of registered state, so it cannot move while
  // the slave stalls. Data is forced to zero when empty to keep it defined.
  assign av.wr_write     = (state == RUN) && !fifo_empty;
  assign av.wr_writedata = fifo_empty ? '0 : fifo_mem[fifo_rptr];

  assign last_write = wr_acc && ((wr_done + AW'(1)) == len_q);

  always_comb begin
    issued_nxt = rd_issued + AW'(rd_acc);
    out_nxt    = outstanding + CW'(rd_acc) - CW'(rd_ret);
    cnt_nxt    = fifo_count + CW'(rd_ret) - CW'(wr_acc);
    credit_nxt = {1'b0, cnt_nxt} + {1'b0, out_nxt};
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!rst && rd_ret) begin
      fifo_mem[fifo_wptr] <= av.rd_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      task_done     <= 1'b0;
      busy          <= 1'b0;
      av.rd_read    <= 1'b0;
      av.rd_address <= '0;
      av.wr_address <= '0;
      len_q         <= '0;
      rd_issued     <= '0;
      wr_done       <= '0;
      outstanding   <= '0;
      fifo_count    <= '0;
      fifo_wptr     <= '0;
      fifo_rptr     <= '0;
    end else begin
      task_done <= 1'b0;
      case (state)
        IDLE: begin
          if (config_done) begin
            av.rd_address <= param_raddr;
            av.wr_address <= param_waddr;
            len_q         <= param_iolen;
            rd_issued     <= '0;
            wr_done       <= '0;
            outstanding   <= '0;
            fifo_count    <= '0;
            fifo_wptr     <= '0;
            fifo_rptr     <= '0;
            busy          <= 1'b1;
            av.rd_read    <= (param_iolen != '0);
            // A zero-length job still passes through RUN for one cycle,
            // giving a fixed two-cycle config_done -> task_done turnaround.
            state         <= RUN;
          end
        end

        RUN: begin
          if (rd_acc) begin
            av.rd_address <= av.rd_address + STRIDE;
          end
          if (rd_ret) begin
            fifo_wptr <= fifo_wptr + FW'(1);
          end
          if (wr_acc) begin
            fifo_rptr     <= fifo_rptr + FW'(1);
            av.wr_address <= av.wr_address + STRIDE;
          end
          rd_issued   <= issued_nxt;
          wr_done     <= wr_done + AW'(wr_acc);
          outstanding <= out_nxt;
          fifo_count  <= cnt_nxt;

          // A read may only be in flight if a FIFO slot is reserved for it.
          // A stalled request stays up: stalls never consume credit, so the
          // same condition still holds on the next cycle.
          av.rd_read <= (issued_nxt < len_q) && (credit_nxt < CREDITS);

          if (last_write || (len_q == '0)) begin
            state      <= DONE;
            task_done  <= 1'b1;
            busy       <= 1'b0;
            av.rd_read <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_ret && !wr_acc && fifo_count[FW]));

endmodule

// File: tb/tb_avalon_rw_ctrl.sv
module tb_avalon_rw_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          config_done = 1'b0;
  logic [DW-1:0] param_raddr = '0;
  logic [DW-1:0] param_waddr = '0;
  logic [AW-1:0] param_iolen = '0;
  logic          task_done;
  logic          busy;

  avalon_rw_ctrl_if #(.DW(DW)) av ();

  avalon_rw_ctrl #(.AW(AW), .DW(DW), .FW(FW)) dut (
    .clk         (clk),
    .rst         (rst),
    .config_done (config_done),
    .param_raddr (param_raddr),
    .param_waddr (param_waddr),
    .param_iolen (param_iolen),
    .task_done   (task_done),
    .busy        (busy),
    .av          (av)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {logic [DW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {int due; logic [DW-1:0] data;} beat_t;

  logic [DW-1:0] exp_rd_q[$];
  wr_t           exp_wr_q[$];
  int            exp_done_q[$];   // absolute cycle, or -1 = cycle after last write
  beat_t         pend_q[$];

  logic [DW-1:0] data_key = '0;
  int lat = 1;
  int rd_wait_pct = 0;
  int wr_wait_pct = 0;
  bit wr_hold = 0;
  logic [DW-1:0] stall_addr = '0;
  int stall_left = 0;
  bit stall_mon = 0;
  int stall_seen = 0;
  int rd_acc_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;

  // Memory contents: word address plus 0x60, scrambled by a per-transfer key.
  function automatic logic [DW-1:0] data_fn(input logic [DW-1:0] a);
    return ((a >> 2) + 32'h60) ^ data_key;
  endfunction

  // ---------------- slave driver ----------------
  always @(posedge clk) begin
    #1;
    av.rd_readdatavalid = 1'b0;
    av.rd_readdata      = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      av.rd_readdatavalid = 1'b1;
      av.rd_readdata      = pend_q[0].data;
      pend_q.delete(0);
    end
    if (stall_left > 0 && av.rd_read === 1'b1 && av.rd_address === stall_addr) begin
      av.rd_waitrequest = 1'b1;
      stall_left--;
    end else begin
      av.rd_waitrequest = ($urandom_range(99) < rd_wait_pct);
    end
    av.wr_waitrequest = wr_hold || ($urandom_range(99) < wr_wait_pct);
  end

  // ---------------- monitor ----------------
  bit            prev_rd_stall = 0;
  logic [DW-1:0] prev_rd_addr;
  bit            prev_wr_stall = 0;
  logic [DW-1:0] prev_wr_addr;
  logic [DW-1:0] prev_wr_data;
  int            mon_e;

  always @(negedge clk) begin
    if (prev_rd_stall)
      chk("rd_hold", {av.rd_read, av.rd_address}, {1'b1, prev_rd_addr});
    if (prev_wr_stall)
      chk("wr_hold", {av.wr_write, av.wr_address, av.wr_writedata},
          {1'b1, prev_wr_addr, prev_wr_data});

    if (stall_mon && av.rd_read === 1'b1 && av.rd_waitrequest === 1'b1) begin
      stall_seen++;
      chk("rd_addr_in_stall", av.rd_address, stall_addr);
    end

    if (av.rd_read === 1'b1 && av.rd_waitrequest === 1'b0) begin
      rd_acc_cnt++;
      if (exp_rd_q.size() == 0) flag("rd_unexpected_read");
      else begin
        chk("rd_address", av.rd_address, exp_rd_q[0]);
        exp_rd_q.delete(0);
      end
      pend_q.push_back(beat_t'{cyc + lat, data_fn(av.rd_address)});
    end

    if (av.wr_write === 1'b1 && av.wr_waitrequest === 1'b0) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_wr_q.size() == 0) flag("wr_unexpected_write");
      else begin
        chk("wr_address", av.wr_address, exp_wr_q[0].addr);
        chk("wr_writedata", av.wr_writedata, exp_wr_q[0].data);
        exp_wr_q.delete(0);
      end
    end

    if (task_done === 1'b1) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
      if (exp_done_q.size() == 0) flag("unexpected_task_done");
      else begin
        mon_e = exp_done_q[0];
        exp_done_q.delete(0);
        if (mon_e < 0) chk("done_cycle", cyc, last_wr_cyc + 1);
        else           chk("done_cycle", cyc, mon_e);
        chk("writes_left_at_done", exp_wr_q.size(), 0);
      end
    end

    prev_rd_stall = !rst && av.rd_read === 1'b1 && av.rd_waitrequest === 1'b1;
    prev_rd_addr  = av.rd_address;
    prev_wr_stall = !rst && av.wr_write === 1'b1 && av.wr_waitrequest === 1'b1;
    prev_wr_addr  = av.wr_address;
    prev_wr_data  = av.wr_writedata;
  end

  // ---------------- stimulus ----------------
  task automatic start_xfer(input logic [DW-1:0] ra, input logic [DW-1:0] wa,
                            input int len, input bit abs_done);
    int c0;
    @(posedge clk); #1;
    param_raddr = ra;
    param_waddr = wa;
    param_iolen = AW'(len);
    config_done = 1'b1;
    c0 = cyc;
    rd_acc_cnt = 0;
    for (int i = 0; i < len; i++) begin
      exp_rd_q.push_back(ra + DW'(i * 4));
      exp_wr_q.push_back(wr_t'{wa + DW'(i * 4), data_fn(ra + DW'(i * 4))});
    end
    if (len == 0)     exp_done_q.push_back(c0 + 2);
    else if (abs_done) exp_done_q.push_back(c0 + len + 3);
    else              exp_done_q.push_back(-1);
    @(posedge clk); #1;
    config_done = 1'b0;
    param_raddr = $urandom;
    param_waddr = $urandom;
    param_iolen = AW'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic flush_exp();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_done_q.size() != 0 || exp_wr_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (exp_done_q.size() != 0 || exp_wr_q.size() != 0) begin
      flag("transfer_timeout");
      flush_exp();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_task_done"}, task_done, 0);
    chk({tag, "_rd_read"},   av.rd_read, 0);
    chk({tag, "_wr_write"},  av.wr_write, 0);
    chk({tag, "_rd_address"}, av.rd_address, 0);
    chk({tag, "_wr_address"}, av.wr_address, 0);
    chk({tag, "_wr_writedata"}, av.wr_writedata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    logic [DW-1:0] ra;
    logic [DW-1:0] wa;
    int len;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Zero-stall, 1-cycle latency: full throughput and exact done cycle.
    data_key = '0; lat = 1; rd_wait_pct = 0; wr_wait_pct = 0;
    start_xfer(32'h100, 32'h200, 4, 1);
    wait_done(200);

    // Zero length.
    start_xfer(32'h140, 32'h240, 0, 0);
    wait_done(50);
    chk("zero_len_reads", rd_acc_cnt, 0);

    // Write backpressure: credits cap reads at the FIFO depth.
    data_key = 32'h5A5A_0000;
    wr_hold = 1;
    start_xfer(32'h1000, 32'h2000, 10, 0);
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("reads_under_wr_stall", rd_acc_cnt, (10 < (1 << FW)) ? 10 : (1 << FW));
    chk("rd_read_under_wr_stall", av.rd_read, 0);
    chk("wr_write_under_wr_stall", av.wr_write, 1);
    wr_hold = 0;
    wait_done(400);

    // Read stall on word 2.
    data_key = 32'h0000_3C3C;
    stall_addr = 32'h108; stall_left = 5; stall_seen = 0; stall_mon = 1;
    start_xfer(32'h100, 32'h300, 6, 0);
    wait_done(200);
    stall_mon = 0;
    chk("rd_stall_cycles", stall_seen, 5);

    // Restart while running is ignored.
    base = done_cnt;
    start_xfer(32'h400, 32'h500, 8, 0);
    repeat (2) @(posedge clk);
    #1;
    param_raddr = 32'h700; param_waddr = 32'h800; param_iolen = AW'(5);
    config_done = 1'b1;
    @(posedge clk); #1;
    config_done = 1'b0;
    wait_done(200);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("restart_done_pulses", done_cnt - base, 1);

    // Reset mid-run with late read beats.
    lat = 3;
    data_key = 32'h1234_0000;
    start_xfer(32'h600, 32'h900, 8, 0);
    base = wr_cnt; k = 0;
    while (wr_cnt - base < 3 && k < 300) begin @(posedge clk); k++; end
    if (wr_cnt - base < 3) flag("mid_run_write_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    flush_exp();
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    pend_q.push_back(beat_t'{cyc + 1, 32'hDEAD_0001});
    pend_q.push_back(beat_t'{cyc + 2, 32'hDEAD_0002});
    base = wr_cnt;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("late_beats_writes", wr_cnt - base, 0);
    chk("late_beats_busy", busy, 0);
    lat = 1;
    start_xfer(32'hA00, 32'hB00, 5, 0);
    wait_done(200);

    // Randomized transfers, including an address wrap.
    for (int t = 0; t < 6; t++) begin
      data_key    = $urandom;
      lat         = $urandom_range(1, 3);
      rd_wait_pct = $urandom_range(0, 40);
      wr_wait_pct = $urandom_range(0, 40);
      ra  = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      wa  = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(1, 20);
      start_xfer(ra, wa, len, 0);
      wait_done(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
